// File: rtl/sync_up_counter_pkg.sv
// Shared constants for the 4-bit synchronous up-counter.
package sync_up_counter_pkg;

    localparam int unsigned      CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(15);

endpackage

// File: rtl/DFlipFlop.sv
// Team D flip-flop cell: rising-edge D input, asynchronous active-high clear.
module DFlipFlop (
    output logic q,
    output logic qBar,
    input  logic D,
    input  logic clk,
    input  logic rst
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= D;
    end

    assign qBar = ~q;

endmodule

// File: rtl/sync_up_counter.sv
// 4-bit synchronous up-counter built from D flip-flops: parallel load, count enable,
// optional saturation, cascade carry (tc) and a sticky overflow flag.
module sync_up_counter
    import sync_up_counter_pkg::*;
#(
    parameter bit SAT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] out,
    output logic             tc,
    output logic             ovf
);

    logic [CNT_W-1:0] q;
    logic [CNT_W-1:0] qbar;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] carry;
    logic             at_max;
    logic             adv;
    logic             step;
    logic             ovf_set;
    logic             ovf_d;
    logic             ovf_qbar;

    // carry[k] is high when bits 0..k-1 are all ones, i.e. bit k toggles on a step
    assign carry[0] = 1'b1;
    for (genvar k = 1; k < CNT_W; k++) begin : g_carry
        assign carry[k] = carry[k-1] & q[k-1];
    end

    assign at_max  = (q == CNT_MAX);
    assign adv     = en & ~load;
    assign step    = adv & ~(SAT_MODE & at_max);
    assign ovf_set = adv & at_max;

    for (genvar i = 0; i < CNT_W; i++) begin : g_bit
        assign d[i] = load ? din[i] : ((step & carry[i]) ? qbar[i] : q[i]);

        DFlipFlop u_dff (
            .q    (q[i]),
            .qBar (qbar[i]),
            .D    (d[i]),
            .clk  (clk),
            .rst  (rst)
        );
    end

    // Sticky overflow: load clears it, otherwise it latches any advance attempted at max
    assign ovf_d = ~load & (ovf_set | ~ovf_qbar);

    DFlipFlop u_ovf (
        .q    (ovf),
        .qBar (ovf_qbar),
        .D    (ovf_d),
        .clk  (clk),
        .rst  (rst)
    );

    assign out = q;
    assign tc  = en & at_max;

endmodule

// File: tb/tb_sync_up_counter.sv
// Randomized self-checking bench: wrapping, saturating and cascaded counters
// compared against an arithmetic reference model.
module tb_sync_up_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;
    logic       ld_h = 1'b0;
    logic [3:0] din_h = 4'd0;

    logic [3:0] out_w, out_s, out_h;
    logic       tc_w, tc_s, tc_h;
    logic       ovf_w, ovf_s, ovf_h;

    int         m_w, m_s, m_h;
    bit         mo_w, mo_s, mo_h;
    int         n_checks = 0;
    int         n_fail = 0;
    string      phase = "reset";

    always #5 clk = ~clk;

    sync_up_counter #(.SAT_MODE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
        .out(out_w), .tc(tc_w), .ovf(ovf_w)
    );

    sync_up_counter #(.SAT_MODE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
        .out(out_s), .tc(tc_s), .ovf(ovf_s)
    );

    // High stage of a cascade driven by the wrapping counter's carry
    sync_up_counter #(.SAT_MODE(1'b0)) dut_h (
        .clk(clk), .rst(rst), .en(tc_w), .load(ld_h), .din(din_h),
        .out(out_h), .tc(tc_h), .ovf(ovf_h)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0d expected %0d at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        check("out_w", 32'(out_w), 32'(m_w));
        check("ovf_w", 32'(ovf_w), 32'(mo_w));
        check("out_s", 32'(out_s), 32'(m_s));
        check("ovf_s", 32'(ovf_s), 32'(mo_s));
        check("out_h", 32'(out_h), 32'(m_h));
        check("ovf_h", 32'(ovf_h), 32'(mo_h));
    endtask

    task automatic check_tc();
        bit exp_w;
        exp_w = en && (m_w == 15);
        check("tc_w", 32'(tc_w), 32'(exp_w));
        check("tc_s", 32'(tc_s), 32'(en && (m_s == 15)));
        check("tc_h", 32'(tc_h), 32'(exp_w && (m_h == 15)));
    endtask

    task automatic model_reset();
        m_w = 0; m_s = 0; m_h = 0;
        mo_w = 0; mo_s = 0; mo_h = 0;
    endtask

    // One rising edge of the reference model, using the inputs held across the edge
    task automatic model_edge();
        bit hi_en;
        hi_en = en && (m_w == 15);
        if (load) begin
            m_w = int'(din); mo_w = 0;
            m_s = int'(din); mo_s = 0;
        end else if (en) begin
            if (m_w == 15) mo_w = 1;
            m_w = (m_w + 1) % 16;
            if (m_s == 15) mo_s = 1;
            else           m_s = m_s + 1;
        end
        if (hi_en) begin
            if (m_h == 15) mo_h = 1;
            m_h = (m_h + 1) % 16;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_outs();
        check_tc();
    endtask

    task automatic set_in(input bit e, input bit l, input logic [3:0] d);
        en = e; load = l; din = d;
        #1;
        check_tc();
    endtask

    // Assert reset between edges, check the immediate clear, release at the next falling edge
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outs();
        check_tc();
        @(negedge clk);
        check_outs();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_outs();
        check_tc();
        rst = 1'b0;

        phase = "sweep";
        set_in(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) tick();

        phase = "load_priority";
        set_in(1'b0, 1'b1, 4'd15);
        tick();
        set_in(1'b1, 1'b1, 4'd5);
        tick();
        check("load_val", 32'(out_w), 32'd5);
        check("load_ovf", 32'(ovf_w), 32'd0);

        phase = "hold";
        set_in(1'b0, 1'b1, 4'd6);
        tick();
        set_in(1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) tick();
        set_in(1'b1, 1'b0, 4'd0);
        tick();
        check("hold_then_inc", 32'(out_w), 32'd7);

        phase = "async_reset";
        set_in(1'b0, 1'b1, 4'd9);
        tick();
        set_in(1'b1, 1'b0, 4'd0);
        async_reset();

        phase = "cascade";
        set_in(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 300; i++) tick();
        check("cascade_val", 32'({out_h, out_w}), 32'd44);
        check("cascade_ovf_h", 32'(ovf_h), 32'd1);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                async_reset();
            end else begin
                set_in($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 12,
                       4'($urandom_range(0, 15)));
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
